alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_regfile4x8.sv | 41 ++++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: ALU op encoding, controller
// state encoding, and the instruction field layout.
package alu_seq_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;
  localparam int OP_W     = 2;
  localparam int ALU_OP_W = 3;

  // Instruction layout: [8] ldi, [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
  localparam int INSTR_W  = 9;
  localparam int LDI_BIT  = 8;
  localparam int OP_LSB   = 6;
  localparam int RD_LSB   = 4;
  localparam int RS1_LSB  = 2;
  localparam int RS2_LSB  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_regfile4x8.sv
// Four 8-bit registers with two combinational read ports, a combinational
// debug read port and one synchronous write port.
// Ports:
//   clk, rst                  clock, async active-high reset (clears all regs)
//   we, waddr, wdata          write port, takes effect on the rising edge
//   raddr_a/rdata_a           read port A
//   raddr_b/rdata_b           read port B
//   dbg_addr/dbg_data         debug read port
module regfile4x8
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Instruction sequencer driving an external single-cycle-latency ALU.
// ALU instructions go IDLE -> EXEC -> WB, LDI goes IDLE -> WB.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid, in_ready        instruction handshake (accept on both high)
//   instr, imm                instruction word and LDI immediate
//   alu_en, alu_op,
//   alu_a, alu_b              ALU request, only non-zero in EXEC
//   alu_out, alu_zero,
//   alu_carry                 ALU result and flags, valid the cycle after alu_en
//   done                      one-cycle pulse in the writeback cycle
//   busy                      inverse of in_ready
//   flag_z, flag_c            architectural flags, updated by ALU instructions
//   dbg_addr, dbg_data        combinational register read
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [DATA_W-1:0]   imm,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  input  logic                alu_carry,
  output logic                done,
  output logic                busy,
  output logic                flag_z,
  output logic                flag_c,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  state_e            state;
  logic              ldi_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              accept;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  op_e               op_in;

  assign accept   = in_valid & in_ready;
  assign busy     = ~in_ready;
  assign op_in    = op_e'(instr[OP_LSB +: OP_W]);
  assign rf_we    = (state == ST_WB);
  assign rf_wdata = ldi_q ? imm_q : alu_out;

  // Sources are read straight from the incoming instruction at the accept
  // edge; every earlier writeback has already landed by then, so dependent
  // instructions see fresh values without forwarding.
  regfile4x8 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr_a  (instr[RS1_LSB +: REG_AW]),
    .raddr_b  (instr[RS2_LSB +: REG_AW]),
    .dbg_addr (dbg_addr),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      alu_en   <= 1'b0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      done     <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      ldi_q    <= 1'b0;
      rd_q     <= '0;
      imm_q    <= '0;
    end else begin
      // ALU request and done are single-cycle; they fall back to zero
      // unless the state below re-arms them.
      alu_en <= 1'b0;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      done   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            ldi_q    <= instr[LDI_BIT];
            rd_q     <= instr[RD_LSB +: REG_AW];
            imm_q    <= imm;
            in_ready <= 1'b0;
            if (instr[LDI_BIT]) begin
              state <= ST_WB;
              done  <= 1'b1;
            end else begin
              state  <= ST_EXEC;
              alu_en <= 1'b1;
              alu_op <= {1'b0, op_in};
              alu_a  <= rdata_a;
              alu_b  <= rdata_b;
            end
          end
        end

        ST_EXEC: begin
          state <= ST_WB;
          done  <= 1'b1;
        end

        ST_WB: begin
          // Register write happens through rf_we on this same edge.
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          if (!ldi_q) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instr;
  logic [7:0] imm;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;
  logic       done;
  logic       busy;
  logic       flag_z;
  logic       flag_c;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] shadow [4];

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .imm       (imm),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .done      (done),
    .busy      (busy),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // External ALU: result one cycle after alu_en, outputs zero otherwise so
  // a stray capture outside an ALU writeback is visible.
  always @(posedge clk) begin
    logic [8:0] r;
    r = 9'h000;
    case (alu_op[1:0])
      2'b00: r = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: r = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: r = {1'b0, alu_a & alu_b};
      default: r = {1'b0, alu_a | alu_b};
    endcase
    if (alu_en) begin
      alu_out   <= r[7:0];
      alu_carry <= r[8];
      alu_zero  <= (r[7:0] == 8'h00);
    end else begin
      alu_out   <= 8'h00;
      alu_carry <= 1'b0;
      alu_zero  <= 1'b0;
    end
  end

  function automatic logic [8:0] mk(input logic ldi, input logic [1:0] op,
                                    input logic [1:0] rd, input logic [1:0] rs1,
                                    input logic [1:0] rs2);
    return {ldi, op, rd, rs1, rs2};
  endfunction

  task automatic exec_instr(input logic [8:0] i, input logic [7:0] m,
                            input logic [7:0] exp_val, input string name);
    logic       is_ldi;
    int         lat;
    int         n;
    int         done_pos;
    int         dcnt;
    logic [1:0] rd;
    logic [7:0] old_v;
    logic [7:0] ea;
    logic [7:0] eb;
    is_ldi = i[8];
    lat    = is_ldi ? 1 : 2;
    rd     = i[5:4];
    old_v  = shadow[rd];
    ea     = shadow[i[3:2]];
    eb     = shadow[i[1:0]];
    @(negedge clk);
    dbg_addr = rd;
    instr    = i;
    imm      = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout: in_ready=%b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 9'h000;
    imm      = 8'h00;
    done_pos = -1;
    dcnt     = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcnt++;
        if (done_pos < 0) done_pos = k;
      end
      if (k == 1 && !is_ldi) begin
        checks++;
        if ({alu_en, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, i[7:6], ea, eb}) begin
          errors++;
          $display("FAIL %s alu_req: en=%b op=%h a=%h b=%h required en=1 op=%h a=%h b=%h",
                   name, alu_en, alu_op, alu_a, alu_b, {1'b0, i[7:6]}, ea, eb);
        end
      end
      if (k == lat) begin
        checks++;
        if (dbg_data !== old_v) begin
          errors++;
          $display("FAIL %s dbg_old_in_wb: got %h required %h", name, dbg_data, old_v);
        end
      end
    end
    checks++;
    if (done_pos != lat || dcnt != 1) begin
      errors++;
      $display("FAIL %s done_latency: first=%0d count=%0d required first=%0d count=1",
               name, done_pos, dcnt, lat);
    end
    checks++;
    if (dbg_data !== exp_val) begin
      errors++;
      $display("FAIL %s rd_value: got %h required %h", name, dbg_data, exp_val);
    end
    checks++;
    if (in_ready !== 1'b1 || alu_en !== 1'b0) begin
      errors++;
      $display("FAIL %s back_idle: in_ready=%b alu_en=%b required 1/0", name, in_ready, alu_en);
    end
    shadow[rd] = exp_val;
  endtask

  task automatic check_flags(input logic ez, input logic ec, input string name);
    checks++;
    if ({flag_z, flag_c} !== {ez, ec}) begin
      errors++;
      $display("FAIL %s flags: z=%b c=%b required z=%b c=%b", name, flag_z, flag_c, ez, ec);
    end
  endtask

  task automatic check_reg(input logic [1:0] a, input logic [7:0] ev, input string name);
    dbg_addr = a;
    #1;
    checks++;
    if (dbg_data !== ev) begin
      errors++;
      $display("FAIL %s r%0d: got %h required %h", name, a, dbg_data, ev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    instr = 9'h000;
    imm = 8'h00;
    dbg_addr = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, alu_en, flag_z, flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: done=%b alu_en=%b z=%b c=%b required all 0",
               done, alu_en, flag_z, flag_c);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== 19'h0) begin
      errors++;
      $display("FAIL reset_alu_bus: op=%h a=%h b=%h required 0", alu_op, alu_a, alu_b);
    end
    for (int r = 0; r < 4; r++) begin
      check_reg(r[1:0], 8'h00, "reset_regs");
      shadow[r] = 8'h00;
    end
  endtask

  task automatic test_add();
    exec_instr(mk(1, 2'b00, 2'd1, 2'd0, 2'd0), 8'hF0, 8'hF0, "ldi_r1_f0");
    exec_instr(mk(1, 2'b00, 2'd2, 2'd0, 2'd0), 8'h20, 8'h20, "ldi_r2_20");
    exec_instr(mk(0, 2'b00, 2'd3, 2'd1, 2'd2), 8'h00, 8'h10, "add_r3");
    check_flags(1'b0, 1'b1, "add_r3");
  endtask

  task automatic test_sub();
    exec_instr(mk(1, 2'b00, 2'd1, 2'd0, 2'd0), 8'h05, 8'h05, "ldi_r1_05");
    exec_instr(mk(1, 2'b00, 2'd2, 2'd0, 2'd0), 8'h07, 8'h07, "ldi_r2_07");
    exec_instr(mk(0, 2'b01, 2'd0, 2'd1, 2'd2), 8'h00, 8'hFE, "sub_borrow");
    check_flags(1'b0, 1'b1, "sub_borrow");
    exec_instr(mk(0, 2'b01, 2'd0, 2'd1, 2'd1), 8'h00, 8'h00, "sub_zero");
    check_flags(1'b1, 1'b0, "sub_zero");
  endtask

  task automatic test_logic();
    exec_instr(mk(1, 2'b00, 2'd1, 2'd0, 2'd0), 8'hCC, 8'hCC, "ldi_r1_cc");
    exec_instr(mk(1, 2'b00, 2'd2, 2'd0, 2'd0), 8'hAA, 8'hAA, "ldi_r2_aa");
    exec_instr(mk(0, 2'b10, 2'd3, 2'd1, 2'd2), 8'h00, 8'h88, "and_r3");
    check_flags(1'b0, 1'b0, "and_r3");
    exec_instr(mk(0, 2'b11, 2'd0, 2'd1, 2'd2), 8'h00, 8'hEE, "or_r0");
    check_flags(1'b0, 1'b0, "or_r0");
    // CC + AA = 0x176: carry set, then LDI of zero must not disturb flags
    exec_instr(mk(0, 2'b00, 2'd3, 2'd1, 2'd2), 8'h00, 8'h76, "add_carry");
    check_flags(1'b0, 1'b1, "add_carry");
    exec_instr(mk(1, 2'b00, 2'd0, 2'd0, 2'd0), 8'h00, 8'h00, "ldi_keeps_flags");
    check_flags(1'b0, 1'b1, "ldi_keeps_flags");
  endtask

  task automatic test_back_to_back();
    logic [8:0] prog [3];
    int acc [3];
    int idx;
    int en_cnt;
    int done_cnt;
    int bad;
    logic prev_en;
    logic will_acc;
    // r1=CC r2=AA: ADD r3=0x76, SUB r0=0x22, OR r3=r3|r1=0xFE
    prog[0] = mk(0, 2'b00, 2'd3, 2'd1, 2'd2);
    prog[1] = mk(0, 2'b01, 2'd0, 2'd1, 2'd2);
    prog[2] = mk(0, 2'b11, 2'd3, 2'd3, 2'd1);
    idx = 0; en_cnt = 0; done_cnt = 0; bad = 0; prev_en = 1'b0;
    for (int j = 0; j < 3; j++) acc[j] = -1;
    @(negedge clk);
    instr = prog[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (alu_en === 1'b1) begin
        en_cnt++;
        if (prev_en) bad++;
      end
      if ((alu_en === 1'b1 || done === 1'b1) && in_ready !== 1'b0) bad++;
      if (busy !== ~in_ready) bad++;
      if (done === 1'b1) done_cnt++;
      prev_en  = alu_en;
      will_acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (will_acc && idx < 3) begin
        acc[idx] = cyc;
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else instr = prog[idx];
      end
    end
    checks++;
    if (idx != 3 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      errors++;
      $display("FAIL b2b_accept_spacing: accepts=%0d at %0d,%0d,%0d required 3 spaced by 3",
               idx, acc[0], acc[1], acc[2]);
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 3", done_cnt);
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL b2b_alu_en_count: got %0d required 3", en_cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_handshake: %0d bad cycles required 0", bad);
    end
    check_reg(2'd0, 8'h22, "b2b");
    check_reg(2'd3, 8'hFE, "b2b");
    check_flags(1'b0, 1'b0, "b2b_or");
    shadow[0] = 8'h22;
    shadow[3] = 8'hFE;
  endtask

  task automatic test_dep_chain();
    exec_instr(mk(1, 2'b00, 2'd1, 2'd0, 2'd0), 8'h01, 8'h01, "ldi_r1_01");
    exec_instr(mk(0, 2'b00, 2'd1, 2'd1, 2'd1), 8'h00, 8'h02, "chain1");
    exec_instr(mk(0, 2'b00, 2'd1, 2'd1, 2'd1), 8'h00, 8'h04, "chain2");
    exec_instr(mk(0, 2'b00, 2'd1, 2'd1, 2'd1), 8'h00, 8'h08, "chain3");
    check_flags(1'b0, 1'b0, "chain3");
  endtask

  task automatic test_reset_mid();
    int n;
    int dcnt;
    exec_instr(mk(1, 2'b00, 2'd1, 2'd0, 2'd0), 8'h33, 8'h33, "ldi_r1_33");
    exec_instr(mk(1, 2'b00, 2'd3, 2'd0, 2'd0), 8'h00, 8'h00, "ldi_r3_00");
    @(negedge clk);
    instr = mk(0, 2'b00, 2'd3, 2'd1, 2'd1);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_exec: alu_en=%b required 1", alu_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (alu_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: alu_en=%b done=%b required 0/0", alu_en, done);
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d pulses required 0", dcnt);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
    check_reg(2'd3, 8'h00, "rstmid");
    check_flags(1'b0, 1'b0, "rstmid");
    for (int r = 0; r < 4; r++) shadow[r] = 8'h00;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_dep_chain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
